button_pio_event_scanner: RTL and testbench

Avalon-MM polling master that sequences the button PIO slave. It does three things in turn:
- periodically reads the PIO edge-capture register (offset 3) and data register (offset 0);
- clears exactly the edge bits it read, using a write-1-to-clear at offset 3;
- converts each captured edge into one event pushed into an internal FIFO, drained through a valid/ready stream, with an irq output for the HPS side.

This replaces per-poll software accesses to the PIO and guarantees no edge is lost between read and clear.

---
 rtl/button_pio_event_scanner.sv | 177 +++++++++++++++++
 tb/tb_button_pio_event_scanner.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_pio_event_scanner.sv
// Avalon-MM polling master for the button PIO. It reads the edge-capture and data registers,
// clears only the edges it read, and queues one event per edge in a first-word fall-through FIFO.
module button_pio_event_scanner #(
    parameter int NUM_BUTTONS = 4,
    parameter int IDXW        = 2,
    parameter int POLL_CYCLES = 50000,
    parameter int FIFO_DEPTH  = 8,
    parameter int FIFO_AW     = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    output logic [1:0]      m_address,
    output logic            m_chipselect,
    output logic            m_write_n,
    output logic [31:0]     m_writedata,
    input  logic [31:0]     m_readdata,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [IDXW-1:0] evt_index,
    output logic            evt_level,
    output logic            irq,
    output logic            overflow,
    input  logic            ovf_clear,
    output logic            busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_EDGE, S_WAIT_EDGE, S_RD_DATA, S_WAIT_DATA, S_CLEAR, S_PUSH
    } state_t;

    localparam int TW = $clog2(POLL_CYCLES);
    localparam logic [TW-1:0] TIMER_START  = TW'(POLL_CYCLES - 1);
    // An empty scan spends two cycles outside IDLE; shortening the reload keeps scan starts
    // exactly POLL_CYCLES apart.
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_CYCLES - 3);
    localparam logic [1:0]    REG_DATA     = 2'd0;
    localparam logic [1:0]    REG_EDGE     = 2'd3;

    state_t                 state, next_state;
    logic [TW-1:0]          timer;
    logic [NUM_BUTTONS-1:0] edge_mask, level_snap, mask_rest, rd_bits;
    logic [IDXW-1:0]        low_idx;
    logic                   push_req;
    logic [1:0]             address_d;
    logic                   chipselect_d, write_n_d;
    logic [31:0]            writedata_d;
    logic                   unused_rdata;

    assign rd_bits      = m_readdata[NUM_BUTTONS-1:0];
    assign unused_rdata = ^m_readdata;
    assign mask_rest    = edge_mask & (edge_mask - NUM_BUTTONS'(1));
    assign busy         = (state != S_IDLE);

    // Scanning from the top down leaves the lowest set bit in low_idx.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (edge_mask[i]) low_idx = IDXW'(i);
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        push_req   = 1'b0;
        unique case (state)
            S_IDLE:      if (enable && timer == '0) next_state = S_RD_EDGE;
            S_RD_EDGE:   next_state = S_WAIT_EDGE;
            S_WAIT_EDGE: next_state = (rd_bits == '0) ? S_IDLE : S_RD_DATA;
            S_RD_DATA:   next_state = S_WAIT_DATA;
            S_WAIT_DATA: next_state = S_CLEAR;
            S_CLEAR:     next_state = S_PUSH;
            S_PUSH: begin
                push_req = 1'b1;
                if (mask_rest == '0) next_state = S_IDLE;
            end
            default:     next_state = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the state being entered so they are registered with it.
    always_comb begin
        address_d    = '0;
        chipselect_d = 1'b0;
        write_n_d    = 1'b1;
        writedata_d  = '0;
        unique case (next_state)
            S_RD_EDGE: begin
                address_d    = REG_EDGE;
                chipselect_d = 1'b1;
            end
            S_RD_DATA: begin
                address_d    = REG_DATA;
                chipselect_d = 1'b1;
            end
            S_CLEAR: begin
                address_d                    = REG_EDGE;
                chipselect_d                 = 1'b1;
                write_n_d                    = 1'b0;
                writedata_d[NUM_BUTTONS-1:0] = edge_mask;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            timer        <= TIMER_START;
            edge_mask    <= '0;
            level_snap   <= '0;
            m_address    <= '0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= '0;
        end else begin
            state        <= next_state;
            m_address    <= address_d;
            m_chipselect <= chipselect_d;
            m_write_n    <= write_n_d;
            m_writedata  <= writedata_d;
            if (state == S_IDLE) begin
                if (!enable)          timer <= TIMER_START;
                else if (timer != '0) timer <= timer - TW'(1);
            end else if (next_state == S_IDLE) begin
                timer <= TIMER_RELOAD;
            end
            if (state == S_WAIT_EDGE)  edge_mask <= rd_bits;
            else if (state == S_PUSH)  edge_mask <= mask_rest;
            if (state == S_WAIT_DATA)  level_snap <= rd_bits;
        end
    end

    // Event FIFO: entries are {level, index}; the entry at rd_ptr is the visible head.
    logic [IDXW:0]      fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               fifo_full, pop, push_ok, drop;
    logic [IDXW:0]      head;

    assign fifo_full = count[FIFO_AW];
    assign evt_valid = (count != '0);
    assign pop       = evt_valid & evt_ready;
    assign push_ok   = push_req & (~fifo_full | pop);
    assign drop      = push_req & fifo_full & ~pop;
    assign head      = fifo_mem[rd_ptr];
    assign evt_index = head[IDXW-1:0];
    assign evt_level = head[IDXW];
    assign irq       = evt_valid;

    // NOTE: storage is left unreset; count gates visibility, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= {level_snap[low_idx], low_idx};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: ;
            endcase
            if (drop)           overflow <= 1'b1;
            else if (ovf_clear) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_pio_event_scanner.sv
// Directed bench: a behavioural button PIO slave plus bus/event monitors around the scanner.
module tb_button_pio_event_scanner;
    localparam int NB = 4, IDXW = 2, POLL = 8, DEPTH = 8, AW = 3;

    logic            clk = 1'b0, reset_n = 1'b0, enable = 1'b0, evt_ready = 1'b0, ovf_clear = 1'b0;
    logic [1:0]      m_address;
    logic            m_chipselect, m_write_n;
    logic [31:0]     m_writedata, m_readdata;
    logic            evt_valid, evt_level, irq, overflow, busy;
    logic [IDXW-1:0] evt_index;

    always #5 clk = ~clk;

    button_pio_event_scanner #(
        .NUM_BUTTONS(NB), .IDXW(IDXW), .POLL_CYCLES(POLL), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_readdata(m_readdata),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_index(evt_index), .evt_level(evt_level),
        .irq(irq), .overflow(overflow), .ovf_clear(ovf_clear), .busy(busy)
    );

    // PIO slave: falling-edge capture, registered read data, write-1-to-clear at offset 3.
    logic [NB-1:0] pio_data = '1, pio_prev = '1;
    logic [31:0]   edge_cap = '0;
    always @(posedge clk) begin
        pio_prev   <= pio_data;
        m_readdata <= '0;
        if (m_chipselect && m_write_n) begin
            if (m_address == 2'd3)      m_readdata <= edge_cap;
            else if (m_address == 2'd0) m_readdata <= 32'(pio_data);
        end
        if (m_chipselect && !m_write_n && m_address == 2'd3)
            edge_cap <= (edge_cap & ~m_writedata) | 32'(pio_prev & ~pio_data);
        else
            edge_cap <= edge_cap | 32'(pio_prev & ~pio_data);
    end

    int          cyc = 0, rd3_cnt = 0, rd0_cnt = 0, wr_cnt = 0;
    logic [1:0]  last_wa = '0;
    logic [31:0] last_wd = '0;
    typedef struct { int idx; int lvl; int cyc; } evt_t;
    evt_t evq[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (evt_valid && evt_ready) evq.push_back('{int'(evt_index), int'(evt_level), cyc});
    end

    always @(negedge clk) begin
        if (m_chipselect) begin
            if (!m_write_n) begin
                wr_cnt  = wr_cnt + 1;
                last_wa = m_address;
                last_wd = m_writedata;
            end else if (m_address == 2'd3) rd3_cnt = rd3_cnt + 1;
            else if (m_address == 2'd0)     rd0_cnt = rd0_cnt + 1;
        end
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, output int c);
        int n = 0;
        while (busy !== lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        c = cyc;
        if (busy !== lvl) check("wait_busy_timeout", busy, lvl);
    endtask

    task automatic run_scan(output int start);
        int d;
        wait_busy(1'b1, start);
        wait_busy(1'b0, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, s2, b, e, d, n, q0, wr0, rd00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cs", m_chipselect, 0);
        check("rst_wrn", m_write_n, 1);
        check("rst_addr", m_address, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_irq", irq, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;

        // Disabled: no scans at all
        repeat (20) @(negedge clk);
        check("disabled_no_rd", rd3_cnt, 0);

        // Periodic empty scans
        enable = 1'b1;
        run_scan(s0);
        run_scan(s1);
        run_scan(s2);
        enable = 1'b0;
        check("period_a", s1 - s0, POLL);
        check("period_b", s2 - s1, POLL);
        check("empty_rd3", rd3_cnt, 3);
        check("empty_no_rd0", rd0_cnt, 0);
        check("empty_no_wr", wr_cnt, 0);

        // Single edge on button 2, data 1011
        rd00 = rd0_cnt;
        wr0  = wr_cnt;
        pio_data = 4'b1011;
        enable   = 1'b1;
        wait_busy(1'b1, b);
        n = 0;
        while (evt_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        e = cyc;
        // busy rises the cycle after timer expiry, so expiry-to-valid of 7 is 6 from here
        check("irq_latency", e - b, 6);
        check("single_idx", evt_index, 2);
        check("single_lvl", evt_level, 0);
        check("single_irq", irq, 1);
        wait_busy(1'b0, d);
        enable = 1'b0;
        check("single_rd0", rd0_cnt - rd00, 1);
        check("single_wr", wr_cnt - wr0, 1);
        check("single_waddr", last_wa, 3);
        check("single_wdata", last_wd, 32'h4);
        check("single_cleared", edge_cap, 0);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check("single_popped", evt_valid, 0);
        check("single_count", evq.size(), 1);

        // Multi-edge: buttons 0,1,3 fall together
        q0 = evq.size();
        pio_data = 4'b1111;
        @(negedge clk);
        pio_data  = 4'b0100;
        evt_ready = 1'b1;
        enable    = 1'b1;
        run_scan(b);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("multi_count", evq.size() - q0, 3);
        check("multi_idx0", evq[q0].idx, 0);
        check("multi_idx1", evq[q0 + 1].idx, 1);
        check("multi_idx2", evq[q0 + 2].idx, 3);
        check("multi_lvl", evq[q0].lvl + evq[q0 + 1].lvl + evq[q0 + 2].lvl, 0);
        check("multi_back2back", evq[q0 + 2].cyc - evq[q0].cyc, 2);
        check("multi_wdata", last_wd, 32'hB);

        // Overflow: 4 + 4 events fill the FIFO, a 9th is dropped
        evt_ready = 1'b0;
        q0 = evq.size();
        for (int k = 0; k < 2; k++) begin
            pio_data = 4'b1111;
            @(negedge clk);
            pio_data = 4'b0000;
            enable   = 1'b1;
            run_scan(b);
            enable = 1'b0;
        end
        check("full_no_ovf", overflow, 0);
        pio_data = 4'b0001;
        @(negedge clk);
        pio_data  = 4'b0000;
        ovf_clear = 1'b1;
        enable    = 1'b1;
        run_scan(b);
        enable    = 1'b0;
        ovf_clear = 1'b0;
        @(negedge clk);
        check("ovf_set_wins", overflow, 1);
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        check("ovf_cleared", overflow, 0);
        check("ovf_still_valid", evt_valid, 1);
        evt_ready = 1'b1;
        repeat (10) @(negedge clk);
        evt_ready = 1'b0;
        check("ovf_retained", evq.size() - q0, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("ovf_idx%0d", i), evq[q0 + i].idx, i % 4);
            check($sformatf("ovf_lvl%0d", i), evq[q0 + i].lvl, 0);
        end
        check("ovf_drained", evt_valid, 0);

        // Race: button 1 falls after the edge register was read
        evt_ready = 1'b1;
        q0 = evq.size();
        pio_data = 4'b1111;
        @(negedge clk);
        pio_data = 4'b0111;
        enable   = 1'b1;
        wait_busy(1'b1, b);
        @(negedge clk);
        pio_data = 4'b0101;
        wait_busy(1'b0, d);
        enable = 1'b0;
        @(negedge clk);
        check("race_wdata", last_wd, 32'h8);
        check("race_pending", edge_cap, 32'h2);
        check("race_first_cnt", evq.size() - q0, 1);
        check("race_first_idx", evq[q0].idx, 3);
        pio_data = 4'b0111;
        enable   = 1'b1;
        run_scan(b);
        enable = 1'b0;
        @(negedge clk);
        check("race_next_wdata", last_wd, 32'h2);
        check("race_next_cnt", evq.size() - q0, 2);
        check("race_next_idx", evq[q0 + 1].idx, 1);
        check("race_next_lvl", evq[q0 + 1].lvl, 1);

        // Reset during PUSH
        evt_ready = 1'b0;
        pio_data = 4'b1111;
        @(negedge clk);
        pio_data = 4'b0000;
        enable   = 1'b1;
        wait_busy(1'b1, b);
        repeat (6) @(negedge clk);
        check("push_valid_pre", evt_valid, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rstpush_valid", evt_valid, 0);
        check("rstpush_busy", busy, 0);
        check("rstpush_cs", m_chipselect, 0);
        check("rstpush_wrn", m_write_n, 1);
        wr0  = wr_cnt;
        rd00 = rd0_cnt;
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("rstpush_no_wr", wr_cnt - wr0, 0);
        check("rstpush_no_rd0", rd0_cnt - rd00, 0);
        check("rstpush_empty", evt_valid, 0);
        check("rstpush_ovf", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
